// File: rtl/pmod_input_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmod_input_filter_pkg
// Description : Shared constants and a saturating-add helper for the PMOD
//               input conditioning stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pmod_input_filter_pkg;

  // 10 us acceptance window at 125 MHz
  localparam int FILT_CYCLES_10US = 1250;

  // Ceiling of the diagnostic glitch counter
  localparam logic [15:0] GLITCH_MAX = 16'hFFFF;

  // Width of the per-bit rise/fall stretch counter (covers any legal STRETCH)
  localparam int STRETCH_W = 16;

  // 16-bit add that clamps at GLITCH_MAX instead of wrapping
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? GLITCH_MAX : sum[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmod_filter_bit.sv
`default_nettype none
// ============================================================================
// Module      : pmod_filter_bit
// Description : One pin of the input filter: 2-flop synchroniser, persistence
//               counter, debounced level, stretched rise/fall flags and a
//               reject strobe for the glitch statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module pmod_filter_bit
  import pmod_input_filter_pkg::*;
#(
  parameter int   FILT_CYCLES = FILT_CYCLES_10US,
  parameter int   CNT_W       = 11,
  parameter int   STRETCH     = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic clk_125mhz,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic reject
);

  logic                 sync1;
  logic                 sync2;
  logic [CNT_W-1:0]     cnt;
  logic [STRETCH_W-1:0] stretch_cnt;
  logic                 pulse_up;

  logic pending;
  logic differs;
  logic accept;

  // cnt != 0 is the PEND state; cnt == 0 is STABLE
  assign pending = (cnt != '0);
  assign differs = (sync2 != dout);
  assign accept  = differs && (cnt == CNT_W'(FILT_CYCLES - 1));
  // The new level collapsed back before reaching the acceptance count
  assign reject  = pending && !differs;

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      sync1 <= INIT;
      sync2 <= INIT;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Persistence counter and debounced level
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= INIT;
    end else if (accept) begin
      cnt  <= '0;
      dout <= sync2;
    end else if (differs) begin
      cnt  <= cnt + CNT_W'(1);
    end else begin
      cnt  <= '0;
    end
  end

  // Stretch counter: holds the edge flag for STRETCH cycles after an accept
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      stretch_cnt <= '0;
      pulse_up    <= 1'b0;
    end else if (accept) begin
      stretch_cnt <= STRETCH_W'(STRETCH);
      pulse_up    <= sync2;
    end else if (stretch_cnt != '0) begin
      stretch_cnt <= stretch_cnt - STRETCH_W'(1);
    end
  end

  assign rise = (stretch_cnt != '0) &&  pulse_up;
  assign fall = (stretch_cnt != '0) && !pulse_up;

endmodule
`default_nettype wire

// File: rtl/pmod_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : pmod_input_filter
// Description : Synchronise and debounce WIDTH raw PMOD pins, produce clean
//               levels, stretched edge flags, an any-change flag and a
//               saturating count of rejected glitches.
//               Legal setup: FILT_CYCLES >= 4, 2**CNT_W > FILT_CYCLES,
//               2 <= STRETCH <= FILT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module pmod_input_filter
  import pmod_input_filter_pkg::*;
#(
  parameter int   WIDTH       = 8,
  parameter int   FILT_CYCLES = FILT_CYCLES_10US,
  parameter int   CNT_W       = 11,
  parameter int   STRETCH     = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic             clk_125mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             glitch_clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic [15:0]      glitch_cnt
);

  logic [WIDTH-1:0] rejects;
  logic [15:0]      reject_pop;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pmod_filter_bit #(
      .FILT_CYCLES (FILT_CYCLES),
      .CNT_W       (CNT_W),
      .STRETCH     (STRETCH),
      .INIT        (INIT)
    ) u_bit (
      .clk_125mhz (clk_125mhz),
      .reset      (reset),
      .din        (din[i]),
      .dout       (dout[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .reject     (rejects[i])
    );
  end

  // Number of bits rejecting a pending level this cycle
  always_comb begin
    reject_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      reject_pop = reject_pop + 16'(rejects[i]);
    end
  end

  // Saturating glitch counter; a clear discards same-cycle increments
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else begin
      glitch_cnt <= sat_add16(glitch_cnt, reject_pop);
    end
  end

  assign changed = |(rise | fall);

endmodule
`default_nettype wire

// File: tb/tb_pmod_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmod_input_filter
// Description : Directed self-checking bench for pmod_input_filter with
//               FILT_CYCLES = 8, STRETCH = 2, INIT = 0.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pmod_input_filter;

  localparam int WIDTH = 8;

  logic             clk_125mhz = 1'b0;
  logic             reset      = 1'b1;
  logic [WIDTH-1:0] din        = '0;
  logic             glitch_clr = 1'b0;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;
  logic [15:0]      glitch_cnt;

  int tests = 0;
  int fails = 0;

  pmod_input_filter #(
    .WIDTH       (WIDTH),
    .FILT_CYCLES (8),
    .CNT_W       (4),
    .STRETCH     (2),
    .INIT        (1'b0)
  ) dut (
    .clk_125mhz (clk_125mhz),
    .reset      (reset),
    .din        (din),
    .glitch_clr (glitch_clr),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .changed    (changed),
    .glitch_cnt (glitch_cnt)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_125mhz);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [7:0] exp_dout;
    logic [7:0] exp_rise;
    din   = 8'hFF;
    reset = 1'b1;
    ticks(3);
    tests++;
    if (dout !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || changed !== 1'b0 || glitch_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: dout=%h rise=%h fall=%h changed=%b glitch=%h required 00/00/00/0/0000",
               dout, rise, fall, changed, glitch_cnt);
    end
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_dout = (e >= 10) ? 8'hFF : 8'h00;
      exp_rise = (e == 10 || e == 11) ? 8'hFF : 8'h00;
      tests++;
      if (dout !== exp_dout || rise !== exp_rise || fall !== 8'h00 ||
          changed !== (exp_rise != 8'h00) || glitch_cnt !== 16'h0) begin
        fails++;
        $display("FAIL release_edge%0d: dout=%h rise=%h fall=%h changed=%b glitch=%h required %h/%h/00/%b/0000",
                 e, dout, rise, fall, changed, glitch_cnt, exp_dout, exp_rise, exp_rise != 8'h00);
      end
    end
  endtask

  task automatic test_glitch_reject();
    logic [7:0] seen_rise;
    din = 8'h00;
    ticks(14);
    tests++;
    if (dout !== 8'h00 || glitch_cnt !== 16'h0) begin
      fails++;
      $display("FAIL fall_to_zero: dout=%h glitch=%h required 00/0000", dout, glitch_cnt);
    end
    seen_rise = '0;
    for (int p = 0; p < 3; p++) begin
      din = 8'h01;
      for (int c = 0; c < 5; c++) begin tick(); seen_rise |= rise; end
      din = 8'h00;
      for (int c = 0; c < 10; c++) begin tick(); seen_rise |= rise; end
    end
    tests++;
    if (dout !== 8'h00 || seen_rise !== 8'h00 || glitch_cnt !== 16'd3) begin
      fails++;
      $display("FAIL short_pulses: dout=%h rise_seen=%h glitch=%0d required 00/00/3", dout, seen_rise, glitch_cnt);
    end
  endtask

  task automatic test_fall();
    logic [7:0] exp_dout;
    logic [7:0] exp_fall;
    logic [7:0] both;
    both = '0;
    din  = 8'h03;
    for (int c = 0; c < 12; c++) begin tick(); both |= rise & fall; end
    tests++;
    if (dout !== 8'h03) begin
      fails++;
      $display("FAIL accept_03: dout=%h required 03", dout);
    end
    din = 8'h00;
    for (int e = 1; e <= 12; e++) begin
      tick();
      both |= rise & fall;
      exp_dout = (e >= 10) ? 8'h00 : 8'h03;
      exp_fall = (e == 10 || e == 11) ? 8'h03 : 8'h00;
      tests++;
      if (dout !== exp_dout || fall !== exp_fall || rise !== 8'h00 || changed !== (exp_fall != 8'h00)) begin
        fails++;
        $display("FAIL fall_edge%0d: dout=%h fall=%h rise=%h changed=%b required %h/%h/00/%b",
                 e, dout, fall, rise, changed, exp_dout, exp_fall, exp_fall != 8'h00);
      end
    end
    tests++;
    if (both !== 8'h00 || glitch_cnt !== 16'd3) begin
      fails++;
      $display("FAIL rise_and_fall: overlap=%h glitch=%0d required 00/3", both, glitch_cnt);
    end
  endtask

  // One-cycle pulse on the given bits; one reject lands three edges later
  task automatic one_cycle_glitch(input logic [7:0] bits);
    din = bits;
    tick();
    din = 8'h00;
    ticks(6);
  endtask

  task automatic test_multi_glitch_saturate();
    logic [15:0] exp_g;
    din = 8'h0F;
    tick();
    din = 8'h00;
    for (int e = 2; e <= 7; e++) begin
      tick();
      exp_g = (e >= 4) ? 16'd7 : 16'd3;
      tests++;
      if (glitch_cnt !== exp_g) begin
        fails++;
        $display("FAIL four_bit_glitch_edge%0d: glitch=%0d required %0d", e, glitch_cnt, exp_g);
      end
    end
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    tests++;
    if (glitch_cnt !== 16'h0) begin
      fails++;
      $display("FAIL clear: glitch=%h required 0000", glitch_cnt);
    end
    // 8191 one-cycle pulses on all pins -> 8 rejects each = 16'hFFF8
    for (int k = 0; k < 8191; k++) begin
      din = 8'hFF;
      tick();
      din = 8'h00;
      tick();
    end
    ticks(6);
    tests++;
    if (glitch_cnt !== 16'hFFF8 || dout !== 8'h00) begin
      fails++;
      $display("FAIL bulk_glitch: glitch=%h dout=%h required FFF8/00", glitch_cnt, dout);
    end
    one_cycle_glitch(8'h0F);
    one_cycle_glitch(8'h03);
    tests++;
    if (glitch_cnt !== 16'hFFFE) begin
      fails++;
      $display("FAIL preload: glitch=%h required FFFE", glitch_cnt);
    end
    one_cycle_glitch(8'h0F);
    tests++;
    if (glitch_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL saturate: glitch=%h required FFFF", glitch_cnt);
    end
    one_cycle_glitch(8'h0F);
    tests++;
    if (glitch_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL saturate_hold: glitch=%h required FFFF", glitch_cnt);
    end
  endtask

  task automatic test_clear_priority();
    din = 8'h01;
    tick();
    din = 8'h00;
    ticks(2);
    tests++;
    if (glitch_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL pre_clear: glitch=%h required FFFF", glitch_cnt);
    end
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    tests++;
    if (glitch_cnt !== 16'h0) begin
      fails++;
      $display("FAIL clear_priority: glitch=%h required 0000", glitch_cnt);
    end
    tick();
    tests++;
    if (glitch_cnt !== 16'h0) begin
      fails++;
      $display("FAIL clear_after: glitch=%h required 0000", glitch_cnt);
    end
  endtask

  task automatic test_reset_mid_pend();
    logic [7:0] exp_rise;
    one_cycle_glitch(8'h02);
    din = 8'h40;
    ticks(12);
    tests++;
    if (glitch_cnt !== 16'd1 || dout !== 8'h40) begin
      fails++;
      $display("FAIL pre_reset: glitch=%0d dout=%h required 1/40", glitch_cnt, dout);
    end
    din = 8'hC0;
    ticks(7);
    reset = 1'b1;
    #1;
    tests++;
    if (dout !== 8'h00 || rise !== 8'h00 || fall !== 8'h00 || changed !== 1'b0 || glitch_cnt !== 16'h0) begin
      fails++;
      $display("FAIL async_reset: dout=%h rise=%h fall=%h changed=%b glitch=%h required 00/00/00/0/0000",
               dout, rise, fall, changed, glitch_cnt);
    end
    ticks(2);
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_rise = (e == 10 || e == 11) ? 8'hC0 : 8'h00;
      tests++;
      if (rise !== exp_rise || fall !== 8'h00) begin
        fails++;
        $display("FAIL rerelease_edge%0d: rise=%h fall=%h required %h/00", e, rise, fall, exp_rise);
      end
    end
    tests++;
    if (dout !== 8'hC0 || glitch_cnt !== 16'h0) begin
      fails++;
      $display("FAIL rerelease_final: dout=%h glitch=%h required C0/0000", dout, glitch_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_glitch_reject();
    test_fall();
    test_multi_glitch_saturate();
    test_clear_priority();
    test_reset_mid_pend();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
